// File: rtl/regfile_write_arbiter_if.sv
// Register-file write arbiter bus: two write requesters (A and B) on one
// side and the registered register-file write port plus status on the other.
interface regfile_write_arbiter_if;
  logic        a_valid;
  logic [4:0]  a_reg;
  logic [31:0] a_data;
  logic        a_ready;
  logic        b_valid;
  logic [4:0]  b_reg;
  logic [31:0] b_data;
  logic        b_ready;
  logic        RegWrite;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic        init_done;
  logic [15:0] conflict_cnt;

  // Requester / observer side
  modport master (
    output a_valid, a_reg, a_data, b_valid, b_reg, b_data,
    input  a_ready, b_ready, RegWrite, WriteReg, WriteData, init_done, conflict_cnt
  );

  // Arbiter side
  modport slave (
    input  a_valid, a_reg, a_data, b_valid, b_reg, b_data,
    output a_ready, b_ready, RegWrite, WriteReg, WriteData, init_done, conflict_cnt
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Register-file write arbiter: after reset optionally zero-sweeps registers
// 1..31, then arbitrates single-cycle writes from requesters A and B onto a
// registered write port. Writes to register 0 are accepted but dropped.
module regfile_write_arbiter #(
  parameter bit INIT_ON_RESET = 1'b1,
  parameter bit FIXED_PRIO    = 1'b0
) (
  input logic                     clk,
  input logic                     startin,
  regfile_write_arbiter_if.slave  bus
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  localparam state_t RESET_STATE = INIT_ON_RESET ? ST_INIT : ST_RUN;

  state_t      state_q, state_d;
  logic [4:0]  ptr_q, ptr_d;
  logic        last_b_q, last_b_d;
  logic        reg_write_q, reg_write_d;
  logic [4:0]  write_reg_q, write_reg_d;
  logic [31:0] write_data_q, write_data_d;
  logic        init_done_q, init_done_d;
  logic [15:0] conflict_cnt_q, conflict_cnt_d;

  logic run_ok;
  logic a_grant;
  logic b_grant;

  // Grant decision: readies are combinational and forced low by reset or the sweep
  always_comb begin
    run_ok  = !startin && (state_q == ST_RUN);
    a_grant = run_ok && bus.a_valid &&
              (!bus.b_valid || FIXED_PRIO || last_b_q);
    b_grant = run_ok && bus.b_valid && !a_grant;
  end

  assign bus.a_ready      = a_grant;
  assign bus.b_ready      = b_grant;
  assign bus.RegWrite     = reg_write_q;
  assign bus.WriteReg     = write_reg_q;
  assign bus.WriteData    = write_data_q;
  assign bus.init_done    = init_done_q;
  assign bus.conflict_cnt = conflict_cnt_q;

  // Next-state logic: sweep writes in INIT, granted writes and conflict count in RUN
  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    last_b_d       = last_b_q;
    reg_write_d    = 1'b0;
    write_reg_d    = write_reg_q;
    write_data_d   = write_data_q;
    init_done_d    = init_done_q;
    conflict_cnt_d = conflict_cnt_q;

    if (state_q == ST_INIT) begin
      reg_write_d  = 1'b1;
      write_reg_d  = ptr_q;
      write_data_d = 32'd0;
      ptr_d        = ptr_q + 5'd1;
      if (ptr_q == 5'd31) begin
        state_d     = ST_RUN;
        init_done_d = 1'b1;
      end
    end else begin
      init_done_d = 1'b1;
      if (bus.a_valid && bus.b_valid && (conflict_cnt_q != 16'hFFFF)) begin
        conflict_cnt_d = conflict_cnt_q + 16'd1;
      end
      // A register-0 write is consumed but leaves the address/data bus untouched
      if (a_grant) begin
        last_b_d    = 1'b0;
        reg_write_d = (bus.a_reg != 5'd0);
        if (bus.a_reg != 5'd0) begin
          write_reg_d  = bus.a_reg;
          write_data_d = bus.a_data;
        end
      end else if (b_grant) begin
        last_b_d    = 1'b1;
        reg_write_d = (bus.b_reg != 5'd0);
        if (bus.b_reg != 5'd0) begin
          write_reg_d  = bus.b_reg;
          write_data_d = bus.b_data;
        end
      end
    end
  end

  // State register with synchronous reset; last grant resets to B so A wins first
  always_ff @(posedge clk) begin
    if (startin) begin
      state_q        <= RESET_STATE;
      ptr_q          <= 5'd1;
      last_b_q       <= 1'b1;
      reg_write_q    <= 1'b0;
      write_reg_q    <= 5'd0;
      write_data_q   <= 32'd0;
      init_done_q    <= 1'b0;
      conflict_cnt_q <= 16'd0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      last_b_q       <= last_b_d;
      reg_write_q    <= reg_write_d;
      write_reg_q    <= write_reg_d;
      write_data_q   <= write_data_d;
      init_done_q    <= init_done_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter (default parameters: sweep on reset,
// round-robin). A transaction-level model predicts readies and the write port.
module tb_regfile_write_arbiter;

  logic clk = 1'b0;
  logic startin;

  regfile_write_arbiter_if bus();

  regfile_write_arbiter #(
    .INIT_ON_RESET(1'b1),
    .FIXED_PRIO   (1'b0)
  ) dut (
    .clk    (clk),
    .startin(startin),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state, expressed as the observable behaviour
  bit          m_sweeping;
  int          m_sweep_next;
  bit          m_a_turn;
  bit          m_wr_en;
  logic [4:0]  m_wr_reg;
  logic [31:0] m_wr_data;
  bit          m_addr_known;
  bit          m_done;
  int          m_conf;

  bit last_a_acc;
  bit last_b_acc;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit rst,
                               input bit av, input logic [4:0] ar, input logic [31:0] ad,
                               input bit bv, input logic [4:0] br, input logic [31:0] bd);
    startin     = rst;
    bus.a_valid = av;
    bus.a_reg   = ar;
    bus.a_data  = ad;
    bus.b_valid = bv;
    bus.b_reg   = br;
    bus.b_data  = bd;
  endtask

  // One cycle: check readies, advance the model, clock, check the write port
  task automatic tick();
    bit run;
    bit exp_a;
    bit exp_b;
    #1;
    run   = !startin && !m_sweeping;
    exp_a = run && bus.a_valid && (!bus.b_valid || m_a_turn);
    exp_b = run && bus.b_valid && !exp_a;
    checkOutput("a_ready", {31'd0, bus.a_ready}, {31'd0, exp_a});
    checkOutput("b_ready", {31'd0, bus.b_ready}, {31'd0, exp_b});
    last_a_acc = exp_a;
    last_b_acc = exp_b;

    if (startin) begin
      m_sweeping   = 1'b1;
      m_sweep_next = 1;
      m_a_turn     = 1'b1;
      m_wr_en      = 1'b0;
      m_wr_reg     = 5'd0;
      m_wr_data    = 32'd0;
      m_addr_known = 1'b1;
      m_done       = 1'b0;
      m_conf       = 0;
    end else if (m_sweeping) begin
      m_wr_en      = 1'b1;
      m_wr_reg     = 5'(m_sweep_next);
      m_wr_data    = 32'd0;
      m_addr_known = 1'b1;
      if (m_sweep_next == 31) begin
        m_sweeping = 1'b0;
        m_done     = 1'b1;
      end
      m_sweep_next++;
    end else begin
      m_done = 1'b1;
      if (bus.a_valid && bus.b_valid && m_conf < 65535) m_conf++;
      m_wr_en = 1'b0;
      if (exp_a || exp_b) begin
        logic [4:0]  r;
        logic [31:0] d;
        r        = exp_a ? bus.a_reg : bus.b_reg;
        d        = exp_a ? bus.a_data : bus.b_data;
        m_a_turn = exp_b;
        if (r != 5'd0) begin
          m_wr_en      = 1'b1;
          m_wr_reg     = r;
          m_wr_data    = d;
          m_addr_known = 1'b1;
        end else begin
          m_addr_known = 1'b0;
        end
      end
    end

    @(posedge clk);
    #1;
    checkOutput("RegWrite", {31'd0, bus.RegWrite}, {31'd0, m_wr_en});
    if (m_addr_known) begin
      checkOutput("WriteReg", {27'd0, bus.WriteReg}, {27'd0, m_wr_reg});
      checkOutput("WriteData", bus.WriteData, m_wr_data);
    end
    checkOutput("init_done", {31'd0, bus.init_done}, {31'd0, m_done});
    checkOutput("conflict_cnt", {16'd0, bus.conflict_cnt}, 32'(m_conf));
    @(negedge clk);
  endtask

  initial begin
    $display("[TB] start");
    m_sweeping = 1'b1; m_sweep_next = 1; m_a_turn = 1'b1; m_wr_en = 1'b0;
    m_wr_reg = 5'd0; m_wr_data = 32'd0; m_addr_known = 1'b0; m_done = 1'b0; m_conf = 0;

    // Reset with A already requesting; A must stay unserved through the sweep
    applyStimulus(1'b1, 1'b1, 5'd3, 32'h1234_5678, 1'b0, 5'd0, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b1, 5'd3, 32'h1234_5678, 1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 31; i++) tick();
    checkOutput("init_done_after_sweep", {31'd0, bus.init_done}, 32'd1);
    tick();

    // Single A write
    applyStimulus(1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0);
    tick();
    checkOutput("a_write_reg5", {27'd0, bus.WriteReg}, 32'd5);
    applyStimulus(1'b0, 1'b0, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0);
    tick();

    // Round-robin under continuous contention; A was granted last, so B leads here
    applyStimulus(1'b0, 1'b1, 5'd7, 32'hAAAA_0001, 1'b1, 5'd9, 32'hBBBB_0002);
    for (int i = 0; i < 4; i++) tick();
    checkOutput("conflict_after_4", {16'd0, bus.conflict_cnt}, 32'd4);

    // B targeting register 0 is accepted and dropped
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hCAFE_F00D);
    tick();
    checkOutput("b_reg0_dropped", {31'd0, bus.RegWrite}, 32'd0);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    tick();

    // Fresh reset, then A wins the first contention
    applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 9; i++) tick();
    // Reset mid-sweep with the next sweep target at register 10
    applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    tick();
    checkOutput("restart_targets_r1", {27'd0, bus.WriteReg}, 32'd1);
    for (int i = 0; i < 30; i++) tick();
    checkOutput("restart_done", {31'd0, bus.init_done}, 32'd1);

    // Randomised requesters that hold their request until accepted
    applyStimulus(1'b0, 1'b1, 5'd11, 32'h0000_1111, 1'b1, 5'd12, 32'h0000_2222);
    tick();
    for (int i = 0; i < 400; i++) begin
      if (!bus.a_valid || last_a_acc) begin
        bus.a_valid = ($urandom_range(0, 2) != 0);
        bus.a_reg   = 5'($urandom);
        bus.a_data  = $urandom;
      end
      if (!bus.b_valid || last_b_acc) begin
        bus.b_valid = ($urandom_range(0, 2) != 0);
        bus.b_reg   = 5'($urandom);
        bus.b_data  = $urandom;
      end
      tick();
    end

    // Reset in RUN with requests pending: nothing granted, nothing written
    applyStimulus(1'b1, 1'b1, 5'd20, 32'h5555_5555, 1'b1, 5'd21, 32'h6666_6666);
    tick();
    checkOutput("reset_in_run_no_write", {31'd0, bus.RegWrite}, 32'd0);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 31; i++) tick();

    // Long contention drives the conflict counter into saturation
    applyStimulus(1'b0, 1'b1, 5'd1, 32'h0000_00A1, 1'b1, 5'd2, 32'h0000_00B2);
    for (int i = 0; i < 65600; i++) tick();
    checkOutput("conflict_saturated", {16'd0, bus.conflict_cnt}, 32'h0000_FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
